// File: rtl/display_pkg.sv
// Shared types and constants for the display_scan slice.
package display_pkg;

  localparam int unsigned NDIG_DEFAULT = 4;
  localparam int unsigned DIV_DEFAULT  = 50000;
  localparam int unsigned GAP_DEFAULT  = 2;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;

  // Bit positions of segments a..g inside seg_t.
  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

endpackage

// File: rtl/display_scan_if.sv
// Producer-side and pin-side signals of display_scan.
interface display_scan_if
  import display_pkg::*;
#(
  parameter int unsigned NDIG = NDIG_DEFAULT
);
  localparam int unsigned DW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic              load;
  logic [4*NDIG-1:0] val;
  seg_t              seg;
  logic [NDIG-1:0]   an;
  logic [DW-1:0]     dig;
  logic              frame;
  logic              pend;

  modport master (output load, val, input seg, an, dig, frame, pend);
  modport slave  (input load, val, output seg, an, dig, frame, pend);
endinterface

// File: rtl/display_onedigit.sv
// Hex nibble to seven-segment glyph, segments a..g active-high (a = MSB).
module display_onedigit
  import display_pkg::*;
(
  input  logic [3:0] x,
  output seg_t       z
);

  always_comb begin
    z = SEG_BLANK;
    unique case (x)
      4'h0: z = 7'b1111110;
      4'h1: z = 7'b0110000;
      4'h2: z = 7'b1101101;
      4'h3: z = 7'b1111001;
      4'h4: z = 7'b0110011;
      4'h5: z = 7'b1011011;
      4'h6: z = 7'b1011111;
      4'h7: z = 7'b1110000;
      4'h8: z = 7'b1111111;
      4'h9: z = 7'b1111011;
      4'hA: z = 7'b1110111;
      4'hB: z = 7'b0011111;
      4'hC: z = 7'b1001110;
      4'hD: z = 7'b0111101;
      4'hE: z = 7'b1001111;
      4'hF: z = 7'b1000111;
      default: z = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Multiplexed seven-segment scanner with frame-aligned value commit.
// DISPLAY_SCAN_LZ_BLANK_EN enables leading-zero suppression.
module display_scan
  import display_pkg::*;
#(
  parameter int unsigned NDIG = NDIG_DEFAULT,
  parameter int unsigned DIV  = DIV_DEFAULT,
  parameter int unsigned GAP  = GAP_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  display_scan_if.slave bus
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned DW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CntLast = CW'(DIV - 1);
  localparam logic [CW-1:0] GapCnt  = CW'(GAP);
  localparam logic [DW-1:0] DigLast = DW'(NDIG - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     dig_q, dig_d;
  logic [4*NDIG-1:0] pv_q, pv_d, sv_q, sv_d;
  logic              pend_q, pend_d;
  logic              run_q, frame_q, wrap;
  logic [NDIG-1:0]   an_q, an_d;
  seg_t              seg_q, seg_d, glyph;
  logic [3:0]        nib;
  logic              lz_blank;

  // run_q holds the scan idle for the first post-reset edge so slot 0 gets a full DIV clocks.
  always_comb begin
    wrap  = (cnt_q == CntLast) && (dig_q == DigLast);
    cnt_d = cnt_q;
    dig_d = dig_q;
    if (run_q) begin
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        dig_d = (dig_q == DigLast) ? '0 : dig_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    pv_d   = pv_q;
    sv_d   = sv_q;
    pend_d = pend_q;
    if (wrap && pend_q) begin
      sv_d   = pv_q;
      pend_d = 1'b0;
    end
    // A load on the wrap clock lands after the commit, so it waits for the next frame.
    if (bus.load) begin
      pv_d   = bus.val;
      pend_d = 1'b1;
    end
  end

  assign nib = sv_d[{dig_d, 2'b00} +: 4];

  display_onedigit u_dec (
    .x(nib),
    .z(glyph)
  );

`ifdef DISPLAY_SCAN_LZ_BLANK_EN
  always_comb begin
    lz_blank = (dig_d != '0);
    for (int i = 0; i < NDIG; i++) begin
      if ((i >= int'(dig_d)) && (sv_d[4*i +: 4] != 4'h0)) lz_blank = 1'b0;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    an_d  = '0;
    seg_d = SEG_BLANK;
    if (cnt_d >= GapCnt) begin
      an_d[dig_d] = 1'b1;
      seg_d       = lz_blank ? SEG_BLANK : glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      dig_q   <= '0;
      pv_q    <= '0;
      sv_q    <= '0;
      pend_q  <= 1'b0;
      frame_q <= 1'b0;
      an_q    <= '0;
      seg_q   <= SEG_BLANK;
    end else begin
      run_q   <= 1'b1;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      pv_q    <= pv_d;
      sv_q    <= sv_d;
      pend_q  <= pend_d;
      frame_q <= wrap;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.an    = an_q;
  assign bus.dig   = dig_q;
  assign bus.frame = frame_q;
  assign bus.pend  = pend_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with NDIG=4, DIV=4, GAP=1.
module tb_display_scan;
  import display_pkg::*;

  localparam int unsigned NDIG = 4;
  localparam int unsigned DIV  = 4;
  localparam int unsigned GAP  = 1;

  localparam seg_t G0 = 7'b1111110;
  localparam seg_t G1 = 7'b0110000;
  localparam seg_t G2 = 7'b1101101;
  localparam seg_t G3 = 7'b1111001;
  localparam seg_t G4 = 7'b0110011;
  localparam seg_t GA = 7'b1110111;
  localparam seg_t GF = 7'b1000111;
`ifdef DISPLAY_SCAN_LZ_BLANK_EN
  localparam seg_t ZLEAD = 7'b0000000;
`else
  localparam seg_t ZLEAD = 7'b1111110;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   k = 0;

  display_scan_if #(.NDIG(NDIG)) bus ();

  display_scan #(.NDIG(NDIG), .DIV(DIV), .GAP(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic advance_to(input int target);
    while (k < target) tick();
  endtask

  // k counts rising edges since rst was released.
  task automatic do_reset();
    rst = 1'b1;
    bus.load = 1'b0;
    bus.val = '0;
    tick();
    tick();
    rst = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    do_reset();
    advance_to(6);
    bus.val = 16'h5555;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    advance_to(9);
    rst = 1'b1;
    repeat (3) tick();
    checks += 5;
    if (bus.an !== 4'b0000) begin failures++; $display("FAIL reset_an got=%b exp=0000", bus.an); end
    if (bus.seg !== 7'b0) begin failures++; $display("FAIL reset_seg got=%b exp=0000000", bus.seg); end
    if (bus.frame !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", bus.frame); end
    if (bus.pend !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", bus.pend); end
    if (bus.dig !== 2'd0) begin failures++; $display("FAIL reset_dig got=%0d exp=0", bus.dig); end
    rst = 1'b0;
    k = 0;
    tick();
    checks += 2;
    if (bus.an !== 4'b0000) begin failures++; $display("FAIL rel_edge1_an got=%b exp=0000", bus.an); end
    if (bus.dig !== 2'd0) begin failures++; $display("FAIL rel_edge1_dig got=%0d exp=0", bus.dig); end
    tick();
    checks += 2;
    if (bus.an !== 4'b0001) begin failures++; $display("FAIL rel_edge2_an got=%b exp=0001", bus.an); end
    if (bus.seg !== G0) begin failures++; $display("FAIL rel_edge2_seg got=%b exp=%b", bus.seg, G0); end
  endtask

  task automatic test_free_run();
    logic [3:0] exp_an;
    seg_t       exp_seg;
    logic       exp_fr;
    int         c, d;
    do_reset();
    for (int n = 1; n <= 64; n++) begin
      tick();
      c = (n - 1) % DIV;
      d = ((n - 1) / DIV) % NDIG;
      exp_an  = (c < GAP) ? 4'b0000 : 4'(1 << d);
      exp_seg = (c < GAP) ? 7'b0 : ((d == 0) ? G0 : ZLEAD);
      exp_fr  = (n > 1) && ((n % 16) == 1);
      checks += 3;
      if (bus.an !== exp_an) begin
        failures++;
        $display("FAIL free_an edge=%0d got=%b exp=%b", n, bus.an, exp_an);
      end
      if (bus.seg !== exp_seg) begin
        failures++;
        $display("FAIL free_seg edge=%0d got=%b exp=%b", n, bus.seg, exp_seg);
      end
      if (bus.frame !== exp_fr) begin
        failures++;
        $display("FAIL free_frame edge=%0d got=%b exp=%b", n, bus.frame, exp_fr);
      end
    end
  endtask

  task automatic test_load();
    int         tgt[4]     = '{18, 22, 26, 30};
    logic [3:0] exp_an[4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seg_t       exp_seg[4] = '{G4, G3, G2, G1};
    bit         found = 1'b0;
    do_reset();
    advance_to(5);
    bus.val = 16'h1234;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.frame === 1'b1) begin
        found = 1'b1;
        break;
      end
      checks++;
      if (bus.pend !== 1'b1) begin
        failures++;
        $display("FAIL load_pend_wait edge=%0d got=%b exp=1", k, bus.pend);
      end
      tick();
    end
    checks += 3;
    if (!found) begin failures++; $display("FAIL load_frame_seen got=0 exp=1"); end
    if (k != 17) begin failures++; $display("FAIL load_frame_edge got=%0d exp=17", k); end
    if (bus.pend !== 1'b0) begin failures++; $display("FAIL load_pend_at_frame got=%b exp=0", bus.pend); end
    for (int i = 0; i < 4; i++) begin
      advance_to(tgt[i]);
      checks += 2;
      if (bus.an !== exp_an[i]) begin
        failures++;
        $display("FAIL load_an dig=%0d got=%b exp=%b", i, bus.an, exp_an[i]);
      end
      if (bus.seg !== exp_seg[i]) begin
        failures++;
        $display("FAIL load_seg dig=%0d got=%b exp=%b", i, bus.seg, exp_seg[i]);
      end
    end
  endtask

  task automatic test_last_wins();
    int         tgt[4]     = '{18, 22, 26, 30};
    logic [3:0] exp_an[4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seg_t       exp_seg[4] = '{G0, GF, ZLEAD, ZLEAD};
    do_reset();
    advance_to(3);
    bus.val = 16'hAAAA;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    advance_to(7);
    bus.val = 16'h00F0;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    checks++;
    if (bus.pend !== 1'b1) begin failures++; $display("FAIL lw_pend got=%b exp=1", bus.pend); end
    advance_to(17);
    checks += 2;
    if (bus.frame !== 1'b1) begin failures++; $display("FAIL lw_frame got=%b exp=1", bus.frame); end
    if (bus.pend !== 1'b0) begin failures++; $display("FAIL lw_pend_clr got=%b exp=0", bus.pend); end
    for (int i = 0; i < 4; i++) begin
      advance_to(tgt[i]);
      checks += 2;
      if (bus.an !== exp_an[i]) begin
        failures++;
        $display("FAIL lw_an dig=%0d got=%b exp=%b", i, bus.an, exp_an[i]);
      end
      if (bus.seg !== exp_seg[i]) begin
        failures++;
        $display("FAIL lw_seg dig=%0d got=%b exp=%b", i, bus.seg, exp_seg[i]);
      end
    end
  endtask

  task automatic test_wrap_load();
    int   tgt_a[4] = '{18, 22, 26, 30};
    int   tgt_b[4] = '{34, 38, 42, 46};
    seg_t exp_b[4] = '{G1, G0, GF, GA};
    do_reset();
    advance_to(9);
    bus.val = 16'h4444;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    advance_to(16);
    bus.val = 16'hAF01;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    checks += 2;
    if (bus.frame !== 1'b1) begin failures++; $display("FAIL wl_frame1 got=%b exp=1", bus.frame); end
    if (bus.pend !== 1'b1) begin failures++; $display("FAIL wl_pend_keep got=%b exp=1", bus.pend); end
    for (int i = 0; i < 4; i++) begin
      advance_to(tgt_a[i]);
      checks += 2;
      if (bus.seg !== G4) begin
        failures++;
        $display("FAIL wl_old_seg dig=%0d got=%b exp=%b", i, bus.seg, G4);
      end
      if (bus.pend !== 1'b1) begin
        failures++;
        $display("FAIL wl_pend_between dig=%0d got=%b exp=1", i, bus.pend);
      end
    end
    advance_to(33);
    checks += 2;
    if (bus.frame !== 1'b1) begin failures++; $display("FAIL wl_frame2 got=%b exp=1", bus.frame); end
    if (bus.pend !== 1'b0) begin failures++; $display("FAIL wl_pend_clr got=%b exp=0", bus.pend); end
    for (int i = 0; i < 4; i++) begin
      advance_to(tgt_b[i]);
      checks++;
      if (bus.seg !== exp_b[i]) begin
        failures++;
        $display("FAIL wl_new_seg dig=%0d got=%b exp=%b", i, bus.seg, exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_discard();
    seg_t exp_seg;
    int   c, d;
    do_reset();
    advance_to(1);
    bus.val = 16'h1234;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    advance_to(19);
    bus.val = 16'h4AF4;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    advance_to(26);
    checks += 2;
    if (bus.pend !== 1'b1) begin failures++; $display("FAIL rd_pend_pre got=%b exp=1", bus.pend); end
    if (bus.seg !== G2) begin failures++; $display("FAIL rd_sv_pre got=%b exp=%b", bus.seg, G2); end
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    k = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      c = (n - 1) % DIV;
      d = ((n - 1) / DIV) % NDIG;
      exp_seg = (c < GAP) ? 7'b0 : ((d == 0) ? G0 : ZLEAD);
      checks += 2;
      if (bus.seg !== exp_seg) begin
        failures++;
        $display("FAIL rd_seg edge=%0d got=%b exp=%b", n, bus.seg, exp_seg);
      end
      if (bus.pend !== 1'b0) begin
        failures++;
        $display("FAIL rd_pend edge=%0d got=%b exp=0", n, bus.pend);
      end
    end
  endtask

  initial begin
    bus.load = 1'b0;
    bus.val = '0;
    test_reset();
    test_free_run();
    test_load();
    test_last_wins();
    test_wrap_load();
    test_reset_discard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed controller for an NDIG-digit common-segment seven-segment display. It holds a committed display value and scans one digit per slot. For each slot it drives the segment bus through a single hex-to-seven-segment decoder and enables the matching digit. It sits between the value producer (counters, FSM status) and the board's segment/anode pins. New values are committed only at frame boundaries, so a frame never tears.

## Interface
- NDIG, 4: number of digits; val width is 4*NDIG.
- DIV, 50000: clocks per digit slot; must be ≥ 2.
- GAP, 2: blanking clocks at the start of each slot, against ghosting; 0 ≤ GAP < DIV.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe; captures val into the pending register.
- val  in  4*NDIG  hex digits; val[3:0] is digit 0 (least significant, rightmost).
- seg  out  7  segments a..g, active-high; seg[6]=a … seg[0]=g.
- an  out  NDIG  one-hot digit enable, active-high; an[i] is digit i.
- dig  out  $clog2(NDIG)  index of the digit in the current slot.
- frame  out  1  one-clock pulse on the clock where dig wraps NDIG-1 → 0.
- pend  out  1  high while a loaded value is waiting to be committed.

## Operation
- Registers:
  - prescaler cnt, 0..DIV-1
  - digit index dig
  - pending value pv and flag pend
  - shadow value sv
- Slot: cnt increments each clock. At cnt==DIV-1, cnt→0 and dig→dig+1. At dig==NDIG-1, dig wraps to 0.
- Frame wrap is the clock where cnt==DIV-1 and dig==NDIG-1:
  - frame=1 for that clock.
  - If pend=1, then sv←pv and pend←0.
- load: pv←val and pend←1.
  - Load while pend=1 overwrites pv; last load wins.
  - Load on the wrap clock is not bypassed. The wrap commits the old pv, then the new val is stored in pv with pend=1, so it is committed at the next wrap.
- Outputs are registered from next-state.
  - When next cnt < GAP: an=0 and seg=0.
  - Otherwise: an=one-hot(next dig), and seg=decode(sv nibble of next dig), using the standard hex glyph set.
- Glyphs: 0=1111110, 1=0110000, 4=0110011, A=1110111, F=1000111.
- rst has priority over everything: cnt=0, dig=0, pv=0, sv=0, pend=0, an=0, seg=0, frame=0. Reset mid-frame discards any pending value.

## Timing
- Slot length is DIV clocks:
  - an=0 for exactly GAP clocks, then asserted for DIV-GAP clocks.
  - Frame period is NDIG*DIV clocks.
- After rst deasserts, digit 0 occupies the first slot. an[0] first rises at the (GAP+1)th rising edge, or at the 1st edge when GAP=0.
- Load-to-display latency:
  - Commit happens at the next frame wrap after load, 1 to NDIG*DIV clocks later.
  - The digit glyph appears at GAP+1 clocks into that digit's slot.
- pend falls on the same edge that frame pulses.
- seg and an change on the same edge, so there is no cycle where an enables one digit while seg carries another digit's glyph.

## Configuration
- DISPLAY_SCAN_LZ_BLANK_EN defined: leading-zero suppression.
  - Digit i>0 is blanked (seg=0, an still asserted) when sv nibbles i..NDIG-1 are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: every digit shows its glyph, including leading zeros.

## Structure
- Package display_pkg holds:
  - SEG_BLANK = 7'b0000000
  - the a..g bit-order constants
  - the default NDIG/DIV/GAP values
  - a seg_t 7-bit typedef
- One sub-module: the existing hex-to-seven-segment decoder display_onedigit (x[3:0] → z[6:0]).
  - It is instantiated once on the mux-selected sv nibble.
  - Blanking is applied after the decoder.

## Test plan
(NDIG=4, DIV=4, GAP=1 unless noted.)
- Reset held 3 clocks mid-scan → an=0000, seg=0, frame=0, pend=0, dig=0. After release, an=0001 from the 2nd edge, with seg=1111110.
- load val=16'h1234 mid-frame → pend=1 until the next frame pulse, then 0. Next frame shows:
  - digit0 slot: an=0001, seg=0110011
  - digit3 slot: an=1000, seg=0110000
- Free run 64 clocks → frame pulses every 16 clocks. Each slot has exactly 1 clock of an=0 and 3 clocks of one-hot an, ordered 0001, 0010, 0100, 1000.
- load 16'hAAAA, then load 16'h00F0 before the wrap → only 00F0 is shown:
  - digit1 seg=1000111 and digit0 seg=1111110.
  - Digits 3,2: seg=0 with DISPLAY_SCAN_LZ_BLANK_EN, seg=1111110 without.
- load on the exact wrap clock while another value is pending → the old pending value is shown this frame, the new one the following frame, and pend stays 1 between.
- rst asserted while pend=1 with sv=16'h1234 → after release all digits show 1111110 and pend=0; the discarded value never appears.
